// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared definitions for the ctrl_seq sequencing controller.
//   - opcode_e      : ISA opcode encoding (5-bit opcode field)
//   - ctrl_state_t  : sequencer FSM states
//   - Alu*          : ALU operation select codes
//   - ctrl_strobe_t : decoded datapath strobes for one instruction
package ctrl_seq_pkg;

  localparam int unsigned OpcBits = 5;
  localparam int unsigned AluBits = 5;

  typedef enum logic [OpcBits-1:0] {
    OpOrr    = 5'd0,
    OpXorB   = 5'd1,
    OpXorG   = 5'd2,
    OpAnd    = 5'd3,
    OpLsl    = 5'd4,
    OpLsr    = 5'd5,
    OpAdd    = 5'd6,
    OpSta    = 5'd7,
    OpLda    = 5'd8,
    OpLdLutL = 5'd9,
    OpLdLutH = 5'd10,
    OpSetL   = 5'd11,
    OpSetH   = 5'd12,
    OpCmp    = 5'd13,
    OpCmpLs  = 5'd14,
    OpBeq    = 5'd15,
    OpJmp    = 5'd16,
    OpLdr    = 5'd17,
    OpStr    = 5'd18,
    OpHlt    = 5'd19
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMemWait,
    StDone
  } ctrl_state_t;

  localparam logic [AluBits-1:0] AluNop   = 5'b00000;
  localparam logic [AluBits-1:0] AluOrr   = 5'b00001;
  localparam logic [AluBits-1:0] AluXorB  = 5'b00010;
  localparam logic [AluBits-1:0] AluAnd   = 5'b00011;
  localparam logic [AluBits-1:0] AluLsl   = 5'b00100;
  localparam logic [AluBits-1:0] AluLsr   = 5'b00101;
  localparam logic [AluBits-1:0] AluCmp   = 5'b00110;
  localparam logic [AluBits-1:0] AluCmpLs = 5'b00111;
  localparam logic [AluBits-1:0] AluXorG  = 5'b01000;
  localparam logic [AluBits-1:0] AluAdd   = 5'b10000;

  // pc_beq_flag marks a branch candidate; the accumulator test is applied by the sequencer.
  // reg_from_mem marks LDR; the register write only fires on memory completion.
  typedef struct packed {
    logic               pc_jmp_flag;
    logic               pc_beq_flag;
    logic               lut_write_en;
    logic               lut_read_en;
    logic               lut_load_hi;
    logic               reg_write_en;
    logic               reg_from_alu;
    logic               reg_from_mem;
    logic               reg_from_acc;
    logic               acc_write_en;
    logic               acc_from_reg;
    logic               acc_from_alu;
    logic               acc_from_imm;
    logic               acc_load_hi;
    logic               mem_req;
    logic               mem_write_en;
    logic               halt;
    logic [AluBits-1:0] alu_op;
  } ctrl_strobe_t;

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: purely combinational opcode -> datapath strobe decode.
//   opcode_i : opcode field of the latched instruction register
//   strobe_o : decoded strobes (ungated; the sequencer qualifies them by state)
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_strobe_t     strobe_o
);

  opcode_e op;
  assign op = opcode_e'(OpcBits'(opcode_i));

  always_comb begin
    strobe_o = '0;
    case (op)
      OpOrr:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluOrr; end
      OpXorB:   begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluXorB; end
      OpXorG:   begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluXorG; end
      OpAnd:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluAnd; end
      OpLsl:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluLsl; end
      OpLsr:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluLsr; end
      OpAdd:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_alu = 1'b1;
                      strobe_o.alu_op = AluAdd; end
      OpSta:    begin strobe_o.reg_write_en = 1'b1; strobe_o.reg_from_acc = 1'b1; end
      OpLda:    begin strobe_o.acc_write_en = 1'b1; strobe_o.acc_from_reg = 1'b1; end
      OpLdLutL: strobe_o.lut_write_en = 1'b1;
      OpLdLutH: begin strobe_o.lut_write_en = 1'b1; strobe_o.lut_load_hi = 1'b1; end
      OpSetL:   begin strobe_o.acc_write_en = 1'b1; strobe_o.acc_from_imm = 1'b1; end
      OpSetH:   begin strobe_o.acc_write_en = 1'b1; strobe_o.acc_from_imm = 1'b1;
                      strobe_o.acc_load_hi = 1'b1; end
      OpCmp:    begin strobe_o.acc_write_en = 1'b1; strobe_o.acc_from_alu = 1'b1;
                      strobe_o.alu_op = AluCmp; end
      OpCmpLs:  begin strobe_o.acc_write_en = 1'b1; strobe_o.acc_from_alu = 1'b1;
                      strobe_o.alu_op = AluCmpLs; end
      OpBeq:    begin strobe_o.lut_read_en = 1'b1; strobe_o.pc_beq_flag = 1'b1; end
      OpJmp:    begin strobe_o.lut_read_en = 1'b1; strobe_o.pc_jmp_flag = 1'b1; end
      OpLdr:    begin strobe_o.mem_req = 1'b1; strobe_o.reg_from_mem = 1'b1; end
      OpStr:    begin strobe_o.mem_req = 1'b1; strobe_o.mem_write_en = 1'b1; end
      OpHlt:    strobe_o.halt = 1'b1;
      default:  strobe_o = '0;  // undefined opcode: NOP
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle sequencing controller (IDLE/FETCH/EXEC/MEM_WAIT/DONE).
//   Clk, Reset (async, active-low)
//   Start, Ack, Busy          : program handshake and status
//   Instruction, Instr_Valid  : instruction memory interface (latched into IR in FETCH)
//   AccInput                  : accumulator value for the BEQ test
//   Mem_Req, Mem_Write_En, Mem_Rdy : variable-latency data memory handshake
//   Fetch_En, PC_*, LUT_*, Reg_*, Acc_*, ALU_Opcode : datapath strobes
//   Timeout_Err               : sticky data-memory timeout flag
// Optional: define CTRL_SEQ_PERF_CNT_EN to add Retired_Cnt and Stall_Cnt (saturating).
// MEM_TIMEOUT must lie in 1..255.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned INSTR_W     = 9,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ALU_OP_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [INSTR_W-1:0]  Instruction,
  input  logic                Instr_Valid,
  input  logic [DATA_W-1:0]   AccInput,
  input  logic                Mem_Rdy,
  output logic                Fetch_En,
  output logic                PC_Jmp_Flag,
  output logic                PC_Beq_Flag,
  output logic                LUT_Write_En,
  output logic                LUT_Read_En,
  output logic                LUT_Load_Hi,
  output logic                Reg_Write_En,
  output logic                Reg_From_ALU,
  output logic                Reg_From_Mem,
  output logic                Reg_From_Acc,
  output logic                Acc_Write_En,
  output logic                Acc_From_Reg,
  output logic                Acc_From_ALU,
  output logic                Acc_From_Imm,
  output logic                Acc_Load_Hi,
  output logic                Mem_Req,
  output logic                Mem_Write_En,
  output logic [ALU_OP_W-1:0] ALU_Opcode,
  output logic                Busy,
  output logic                Ack,
  output logic                Timeout_Err
`ifdef CTRL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         Retired_Cnt,
  output logic [31:0]         Stall_Cnt
`endif
);

  localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t        state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [7:0]         tmo_q, tmo_d;
  logic               tmo_err_q, tmo_err_d;

  ctrl_strobe_t dec;
  logic         halt;
  logic         mem_phase;
  logic         acc_is_one;

  ctrl_seq_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode_i (ir_q[INSTR_W-1 -: OPC_W]),
    .strobe_o (dec)
  );

  // An all-ones IR (e.g. erased instruction memory) halts just like HLT.
  assign halt       = dec.halt | (&ir_q);
  assign mem_phase  = ((state_q == StExec) & ~halt & dec.mem_req) | (state_q == StMemWait);
  assign acc_is_one = (AccInput == DATA_W'(1));

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    unique case (state_q)
      StIdle: begin
        if (Start) state_d = StFetch;
      end
      StFetch: begin
        if (Instr_Valid) begin
          ir_d    = Instruction;
          state_d = StExec;
        end
      end
      StExec: begin
        if (halt) begin
          state_d = StDone;
        end else if (dec.mem_req && !Mem_Rdy) begin
          state_d = StMemWait;
          tmo_d   = '0;
        end else begin
          state_d = StFetch;
        end
      end
      StMemWait: begin
        tmo_d = tmo_q + 8'd1;
        // Completion wins over expiry in the same cycle.
        if (Mem_Rdy) begin
          state_d = StFetch;
        end else if (tmo_q == TmoLast) begin
          state_d   = StDone;
          tmo_err_d = 1'b1;
        end
      end
      StDone: begin
        if (Start) begin
          state_d   = StFetch;
          tmo_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_comb begin
    Fetch_En     = 1'b0;
    PC_Jmp_Flag  = 1'b0;
    PC_Beq_Flag  = 1'b0;
    LUT_Write_En = 1'b0;
    LUT_Read_En  = 1'b0;
    LUT_Load_Hi  = 1'b0;
    Reg_Write_En = 1'b0;
    Reg_From_ALU = 1'b0;
    Reg_From_Mem = 1'b0;
    Reg_From_Acc = 1'b0;
    Acc_Write_En = 1'b0;
    Acc_From_Reg = 1'b0;
    Acc_From_ALU = 1'b0;
    Acc_From_Imm = 1'b0;
    Acc_Load_Hi  = 1'b0;
    Mem_Req      = 1'b0;
    Mem_Write_En = 1'b0;
    ALU_Opcode   = '0;
    Busy         = (state_q == StFetch) | (state_q == StExec) | (state_q == StMemWait);
    // Ack falls combinationally in the cycle Start is seen in DONE.
    Ack          = (state_q == StDone) & ~Start;
    Timeout_Err  = tmo_err_q;

    if (state_q == StExec) begin
      ALU_Opcode = ALU_OP_W'(dec.alu_op);
      if (!halt && !dec.mem_req) begin
        Fetch_En     = 1'b1;
        PC_Jmp_Flag  = dec.pc_jmp_flag;
        PC_Beq_Flag  = dec.pc_beq_flag & acc_is_one;
        LUT_Write_En = dec.lut_write_en;
        LUT_Read_En  = dec.lut_read_en;
        LUT_Load_Hi  = dec.lut_load_hi;
        Reg_Write_En = dec.reg_write_en;
        Reg_From_ALU = dec.reg_from_alu;
        Reg_From_Acc = dec.reg_from_acc;
        Acc_Write_En = dec.acc_write_en;
        Acc_From_Reg = dec.acc_from_reg;
        Acc_From_ALU = dec.acc_from_alu;
        Acc_From_Imm = dec.acc_from_imm;
        Acc_Load_Hi  = dec.acc_load_hi;
      end
    end

    if (mem_phase) begin
      Mem_Req      = 1'b1;
      Mem_Write_En = dec.mem_write_en;
      if (Mem_Rdy) begin
        Fetch_En     = 1'b1;
        Reg_Write_En = dec.reg_from_mem;
        Reg_From_Mem = dec.reg_from_mem;
      end
    end
  end

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;
  logic        cnt_clr, stall_inc;

  assign cnt_clr   = Start & ((state_q == StIdle) | (state_q == StDone));
  assign stall_inc = (state_q == StMemWait) | ((state_q == StFetch) & ~Instr_Valid);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else if (cnt_clr) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (Fetch_En && !(&retired_q)) retired_q <= retired_q + 32'd1;
      if (stall_inc && !(&stall_q))  stall_q   <= stall_q + 32'd1;
    end
  end

  assign Retired_Cnt = retired_q;
  assign Stall_Cnt   = stall_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: self-checking bench for ctrl_seq. Builds per-cycle expected outputs from an
// instruction-level model (ISA table + handshake rules) and compares every cycle.
module tb_ctrl_seq;

  localparam int unsigned Tmo = 15;

  localparam logic [4:0] OP_ORR = 5'd0,  OP_XORB = 5'd1,  OP_XORG = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_LSL = 5'd4,  OP_LSR = 5'd5,   OP_ADD = 5'd6,   OP_STA = 5'd7;
  localparam logic [4:0] OP_LDA = 5'd8,  OP_LUTL = 5'd9,  OP_LUTH = 5'd10, OP_SETL = 5'd11;
  localparam logic [4:0] OP_SETH = 5'd12, OP_CMP = 5'd13, OP_CMPLS = 5'd14, OP_BEQ = 5'd15;
  localparam logic [4:0] OP_JMP = 5'd16, OP_LDR = 5'd17,  OP_STR = 5'd18,  OP_HLT = 5'd19;

  typedef struct packed {
    logic fetch_en, pc_jmp, pc_beq, lut_we, lut_re, lut_hi, reg_we, reg_alu, reg_mem, reg_acc;
    logic acc_we, acc_reg, acc_alu, acc_imm, acc_hi, mem_req, mem_we, busy, ack, terr;
    logic [4:0] alu;
  } outv_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] instruction = '0;
  logic       instr_valid = 1'b0;
  logic [7:0] acc_input = '0;
  logic       mem_rdy = 1'b0;

  logic fetch_en, pc_jmp, pc_beq, lut_we, lut_re, lut_hi, reg_we, reg_alu, reg_mem, reg_acc;
  logic acc_we, acc_reg, acc_alu, acc_imm, acc_hi, mem_req, mem_we, busy, ack, terr;
  logic [4:0] alu_op;
`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic terr_m = 1'b0;
  int unsigned retired_m = 0;
  int unsigned stall_m = 0;

  ctrl_seq dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .Start        (start),
    .Instruction  (instruction),
    .Instr_Valid  (instr_valid),
    .AccInput     (acc_input),
    .Mem_Rdy      (mem_rdy),
    .Fetch_En     (fetch_en),
    .PC_Jmp_Flag  (pc_jmp),
    .PC_Beq_Flag  (pc_beq),
    .LUT_Write_En (lut_we),
    .LUT_Read_En  (lut_re),
    .LUT_Load_Hi  (lut_hi),
    .Reg_Write_En (reg_we),
    .Reg_From_ALU (reg_alu),
    .Reg_From_Mem (reg_mem),
    .Reg_From_Acc (reg_acc),
    .Acc_Write_En (acc_we),
    .Acc_From_Reg (acc_reg),
    .Acc_From_ALU (acc_alu),
    .Acc_From_Imm (acc_imm),
    .Acc_Load_Hi  (acc_hi),
    .Mem_Req      (mem_req),
    .Mem_Write_En (mem_we),
    .ALU_Opcode   (alu_op),
    .Busy         (busy),
    .Ack          (ack),
    .Timeout_Err  (terr)
`ifdef CTRL_SEQ_PERF_CNT_EN
    ,
    .Retired_Cnt  (retired_cnt),
    .Stall_Cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic outv_t sample();
    outv_t o;
    o = {fetch_en, pc_jmp, pc_beq, lut_we, lut_re, lut_hi, reg_we, reg_alu, reg_mem, reg_acc,
         acc_we, acc_reg, acc_alu, acc_imm, acc_hi, mem_req, mem_we, busy, ack, terr, alu_op};
    return o;
  endfunction

  // Datapath strobes an instruction must raise in its EXEC cycle.
  function automatic outv_t isa_exec(input logic [4:0] op);
    outv_t e;
    e = '0;
    case (op)
      OP_ORR:   begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b00001; end
      OP_XORB:  begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b00010; end
      OP_XORG:  begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b01000; end
      OP_AND:   begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b00011; end
      OP_LSL:   begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b00100; end
      OP_LSR:   begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b00101; end
      OP_ADD:   begin e.reg_we = 1; e.reg_alu = 1; e.alu = 5'b10000; end
      OP_STA:   begin e.reg_we = 1; e.reg_acc = 1; end
      OP_LDA:   begin e.acc_we = 1; e.acc_reg = 1; end
      OP_LUTL:  e.lut_we = 1;
      OP_LUTH:  begin e.lut_we = 1; e.lut_hi = 1; end
      OP_SETL:  begin e.acc_we = 1; e.acc_imm = 1; end
      OP_SETH:  begin e.acc_we = 1; e.acc_imm = 1; e.acc_hi = 1; end
      OP_CMP:   begin e.acc_we = 1; e.acc_alu = 1; e.alu = 5'b00110; end
      OP_CMPLS: begin e.acc_we = 1; e.acc_alu = 1; e.alu = 5'b00111; end
      OP_BEQ:   e.lut_re = 1;
      OP_JMP:   begin e.lut_re = 1; e.pc_jmp = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic outv_t busy_v();
    outv_t e;
    e = '0;
    e.busy = 1'b1;
    e.terr = terr_m;
    return e;
  endfunction

  task automatic chk_out(input string tag, input outv_t e);
    outv_t o;
    o = sample();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(input string tag, input outv_t e);
    @(negedge clk);
    chk_out(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic start_from_idle();
    start = 1'b1;
    cyc("start_idle", '0);
    start = 1'b0;
    retired_m = 0;
    stall_m = 0;
  endtask

  task automatic start_from_done();
    outv_t e;
    e = '0;
    e.terr = terr_m;  // Ack already low, error still visible this cycle
    start = 1'b1;
    cyc("start_done", e);
    start = 1'b0;
    terr_m = 1'b0;
    retired_m = 0;
    stall_m = 0;
  endtask

  task automatic done_cycles(input int n);
    outv_t e;
    e = '0;
    e.ack = 1'b1;
    e.terr = terr_m;
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'($urandom);
      instruction = 9'($urandom);
      mem_rdy = 1'($urandom);
      cyc("done", e);
    end
  endtask

  task automatic do_fetch(input logic [8:0] instr, input int unsigned gaps);
    for (int i = 0; i < int'(gaps); i++) begin
      instr_valid = 1'b0;
      instruction = 9'($urandom);
      mem_rdy = 1'($urandom);
      stall_m++;
      cyc("fetch_wait", busy_v());
    end
    instr_valid = 1'b1;
    instruction = instr;
    mem_rdy = 1'($urandom);
    cyc("fetch", busy_v());
    // EXEC decodes the latched copy, so the bus may change freely now.
    instr_valid = 1'($urandom);
    instruction = 9'($urandom);
  endtask

  // lat: cycles after EXEC until Mem_Rdy (0 = same cycle); lat > Tmo never answers.
  task automatic do_instr(input logic [8:0] instr, input int unsigned gaps,
                          input int unsigned lat, input logic [7:0] acc);
    logic [4:0] op;
    outv_t e;
    logic is_str;
    op = instr[8:4];
    do_fetch(instr, gaps);
    acc_input = acc;
    if (instr == 9'h1FF || op == OP_HLT) begin
      mem_rdy = 1'($urandom);
      cyc("exec_halt", busy_v());
    end else if (op == OP_LDR || op == OP_STR) begin
      is_str = (op == OP_STR);
      for (int k = 0; k <= int'(Tmo) && k <= int'(lat); k++) begin
        mem_rdy = (k == int'(lat));
        e = busy_v();
        e.mem_req = 1'b1;
        e.mem_we = is_str;
        if (mem_rdy) begin
          e.fetch_en = 1'b1;
          e.reg_we = ~is_str;
          e.reg_mem = ~is_str;
        end
        if (k > 0) stall_m++;
        cyc((k == 0) ? "exec_mem" : "mem_wait", e);
      end
      mem_rdy = 1'b0;
      if (lat > Tmo) terr_m = 1'b1;
      else retired_m++;
    end else begin
      mem_rdy = 1'($urandom);
      e = isa_exec(op);
      e.fetch_en = 1'b1;
      e.busy = 1'b1;
      e.terr = terr_m;
      if (op == OP_BEQ) e.pc_beq = (acc == 8'h01);
      cyc("exec", e);
      retired_m++;
    end
  endtask

  task automatic chk_counters(input string tag);
`ifdef CTRL_SEQ_PERF_CNT_EN
    @(negedge clk);
    chk32({tag, "_retired"}, retired_cnt, retired_m);
    chk32({tag, "_stall"}, stall_cnt, stall_m);
    @(posedge clk);
    #1;
`else
    if (tag.len() == 0) $display("empty counter tag");
`endif
  endtask

  initial begin
    logic [4:0] op;
    logic [3:0] arg;
    logic [7:0] acc;
    outv_t e;

    repeat (2) @(posedge clk);
    #1;
    cyc("reset", '0);
    rst_n = 1'b1;
    cyc("idle", '0);
    mem_rdy = 1'b1;
    cyc("idle_memrdy", '0);
    mem_rdy = 1'b0;
    start_from_idle();

    do_instr({OP_ADD, 4'h3}, 0, 0, 8'h00);
    do_instr({OP_LDR, 4'h1}, 1, 3, 8'h00);
    do_instr({OP_STR, 4'h2}, 0, 0, 8'h00);
    do_instr({OP_BEQ, 4'h4}, 0, 0, 8'h01);
    do_instr({OP_BEQ, 4'h4}, 2, 0, 8'h02);
    do_instr({OP_JMP, 4'h5}, 0, 0, 8'h01);
    do_instr({5'd25, 4'h0}, 0, 0, 8'h00);
    do_instr({OP_CMPLS, 4'h7}, 1, 0, 8'h00);
    do_instr({OP_SETH, 4'h9}, 0, 0, 8'h00);

    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == OP_HLT) op = OP_ADD;
      arg = (op == 5'd31) ? 4'($urandom_range(0, 14)) : 4'($urandom);
      acc = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'($urandom);
      do_instr({op, arg}, $urandom_range(0, 3), $urandom_range(0, 5), acc);
    end

    // Start held high while busy must be ignored.
    start = 1'b1;
    do_instr({OP_ADD, 4'h1}, 2, 0, 8'h00);
    do_instr({OP_LDR, 4'h1}, 0, 2, 8'h00);
    start = 1'b0;

    do_instr(9'h1FF, 0, 0, 8'h00);
    done_cycles(4);
    chk_counters("after_1ff");
    start_from_done();

    do_instr({OP_LSL, 4'h0}, 0, 0, 8'h00);
    do_instr({OP_STR, 4'h6}, 0, Tmo + 10, 8'h00);
    done_cycles(3);
    chk_counters("after_timeout");
    start_from_done();

    // Ready on the last permitted wait cycle completes normally.
    do_instr({OP_STR, 4'h6}, 1, Tmo, 8'h00);
    do_instr({OP_LDR, 4'h6}, 0, Tmo, 8'h00);
    do_instr({OP_HLT, 4'h0}, 0, 0, 8'h00);
    done_cycles(2);
    chk_counters("after_hlt");
    start_from_done();

    // Asynchronous reset in the middle of MEM_WAIT.
    do_fetch({OP_LDR, 4'h3}, 0);
    mem_rdy = 1'b0;
    e = busy_v();
    e.mem_req = 1'b1;
    cyc("exec_mem_pre_rst", e);
    cyc("mem_wait_pre_rst", e);
    rst_n = 1'b0;
    #1;
    chk_out("reset_async", '0);
    terr_m = 1'b0;
    retired_m = 0;
    stall_m = 0;
    cyc("reset_hold", '0);
    chk_counters("after_reset");
    rst_n = 1'b1;
    cyc("idle_after_rst", '0);
    start_from_idle();
    do_instr({OP_ADD, 4'h2}, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised, multi-cycle sequencing controller; next generation of the single-cycle combinational decoder.
- Latches each instruction into an internal IR, runs a FETCH/EXEC/MEM_WAIT/DONE state machine and drives the datapath strobes (PC, LUT, RegFile, Accumulator, Mem).
- Adds variable-latency data-memory handshaking with a timeout, and a Start/Ack program handshake.
- Sits between instruction memory and the datapath, replacing the combinational control unit in the top level.

Parameters:
- INSTR_W, 9, instruction width; opcode is Instruction[INSTR_W-1 -: OPC_W].
- OPC_W, 5, opcode field width.
- DATA_W, 8, accumulator width used for the branch test.
- ALU_OP_W, 5, ALU_Opcode width.
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort; must be 1..255.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse; begins program execution.
- Instruction  in  INSTR_W  machine code from instruction memory.
- Instr_Valid  in  1  Instruction is valid this cycle.
- AccInput  in  DATA_W  accumulator value for BEQ.
- Mem_Rdy  in  1  data memory completes the current request.
- Fetch_En  out  1  PC advance strobe; pulses once per retired instruction.
- PC_Jmp_Flag, PC_Beq_Flag  out  1 each  PC control.
- LUT_Write_En, LUT_Read_En, LUT_Load_Hi  out  1 each  LUT control.
- Reg_Write_En, Reg_From_ALU, Reg_From_Mem, Reg_From_Acc  out  1 each  RegFile control.
- Acc_Write_En, Acc_From_Reg, Acc_From_ALU, Acc_From_Imm, Acc_Load_Hi  out  1 each  accumulator control.
- Mem_Req  out  1  data-memory request.
- Mem_Write_En  out  1  store qualifier.
- ALU_Opcode  out  ALU_OP_W  ALU operation select.
- Busy  out  1  high in FETCH, EXEC and MEM_WAIT.
- Ack  out  1  program done; high in DONE.
- Timeout_Err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (asynchronous, any state): state IDLE, IR=0, timeout counter 0; every output 0.
- IDLE: all strobes 0. Start moves to FETCH next cycle.
- FETCH: waits for Instr_Valid. On Instr_Valid, Instruction is latched into IR and the FSM moves to EXEC.
- EXEC: decode uses IR only, so Instruction may change freely.
  - Strobes are asserted for exactly this one cycle, with the same per-opcode mapping as the existing ISA: ORR, XOR_B, XOR_G, AND, LSL, LSR, ADD, STA, LDA, LD_LUT_L/H, SET_L/H, CMP, CMP_LS.
  - Fetch_En=1 in the same cycle; next state FETCH.
  - BEQ: LUT_Read_En=1. PC_Beq_Flag = (AccInput == DATA_W'(1)), sampled in EXEC.
  - JMP: LUT_Read_En=1, PC_Jmp_Flag=1.
  - Undefined opcode: NOP. Only Fetch_En=1.
- HLT, or an all-ones IR: no strobes, no Fetch_En; next state DONE.
- LDR/STR in EXEC: Mem_Req=1; STR also drives Mem_Write_En=1.
  - If Mem_Rdy=1 in the same cycle, the access completes now.
  - Otherwise go to MEM_WAIT and clear the timeout counter.
- MEM_WAIT: Mem_Req (and Mem_Write_En for STR) held high; counter increments each cycle.
- Memory completion cycle (Mem_Rdy=1):
  - LDR: Reg_Write_En=1, Reg_From_Mem=1.
  - Both LDR and STR: Fetch_En=1; next state FETCH.
- Timeout: counter reaches MEM_TIMEOUT with Mem_Rdy=0.
  - Timeout_Err set; Mem_Req dropped; next state DONE; no register write.
  - Mem_Rdy arriving in the same cycle as expiry wins: the access completes normally.
- DONE: Ack=1, Busy=0, all strobes 0.
  - Start returns to FETCH; Ack drops that cycle.
  - Timeout_Err clears only on reset or on Start from DONE.
- Start while Busy is ignored.
- Mem_Rdy outside an access is ignored.
- ALU_Opcode is driven only in EXEC; otherwise 0.

Optional Feature:
- Macro: CTRL_SEQ_PERF_CNT_EN.
- Defined: adds outputs Retired_Cnt (32 bits, +1 per Fetch_En) and Stall_Cnt (32 bits, +1 per MEM_WAIT cycle and per FETCH cycle with Instr_Valid=0).
  - Both counters saturate at all-ones.
  - Both clear on reset and on Start from IDLE or DONE.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Decomposition:
- Definitions package: the existing opcode enum, plus ctrl_state_t (IDLE, FETCH, EXEC, MEM_WAIT, DONE), ALU opcode localparams, and a ctrl_strobe_t packed struct of all strobes.
- Sub-module ctrl_seq_decode: purely combinational, IR opcode -> ctrl_strobe_t.
  - ctrl_seq gates the struct by state and owns the FSM, timeout and counters.

Test Plan:
- Reset low mid-MEM_WAIT -> next sample shows all outputs 0 and state IDLE. After Reset high, Start -> FETCH.
- Start, then ADD with Instr_Valid=1 -> one cycle later exactly one EXEC cycle with Reg_Write_En=1, Reg_From_ALU=1, ALU_Opcode=5'b10000, Fetch_En=1.
- LDR with Mem_Rdy raised 3 cycles after EXEC -> Mem_Req high for 4 cycles; Reg_Write_En and Reg_From_Mem only in the 4th; exactly one Fetch_En.
- STR with Mem_Rdy held 0 and MEM_TIMEOUT=15 -> Timeout_Err=1 and Ack=1 after 15 MEM_WAIT cycles; Mem_Write_En never toggles mid-access.
- BEQ with AccInput=8'h01 -> PC_Beq_Flag=1; with AccInput=8'h02 -> 0. LUT_Read_En=1 in both cases.
- Instruction 9'h1FF -> DONE; Ack stays 1 and Busy stays 0 until the next Start. With CTRL_SEQ_PERF_CNT_EN, Retired_Cnt equals the count of non-halt instructions.
